// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the quantum round-robin flux scheduler.
package flux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    localparam int STAT_WIDTH = 16;

    // Width of a flux index; a single flux still gets a 1-bit tag.
    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

endpackage

// File: rtl/flux_rr_scheduler_rr_pick.sv
// rr_pick: combinational circular first-ready search starting at 'start'.
// 'start' must already lie in 0..N-1; the scan wraps N-1 -> 0 explicitly,
// so N need not be a power of two.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] ready,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);

    // Scan N candidates from start, keeping the first ready one.
    always_comb begin
        int idx;
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && ready[idx]) begin
                found = 1'b1;
                index = W'(idx);
            end
        end
    end

endmodule

// File: rtl/flux_rr_scheduler.sv
// flux_rr_scheduler: quantum-based round-robin grant for a shared tagged actor.
// A granted flux keeps the actor for up to QUANTUM transfers; full stalls the
// burst without losing the turn, a starved owner hands over in the same cycle.
// Optional per-flux fire counters: define FLUX_SCHED_STATS_EN.
//
//   state | meaning
//   IDLE  | no owner; search from last+1 each cycle
//   BURST | owner holds the actor, cnt transfers done so far
module flux_rr_scheduler
    import flux_sched_pkg::*;
#(
    parameter int FLUX    = 2,
    parameter int QUANTUM = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FLUX-1:0]               empty_a,
    input  logic [FLUX-1:0]               empty_b,
    input  logic                          full,
    output logic [FLUX-1:0]               read_a,
    output logic [FLUX-1:0]               read_b,
    output logic                          write,
    output logic [tag_width(FLUX)-1:0]    tag,
    output logic [tag_width(FLUX)-1:0]    owner,
    output logic                          busy
`ifdef FLUX_SCHED_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [FLUX*STAT_WIDTH-1:0]    stat_cnt
`endif
);

    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int CNT_WIDTH = $clog2(QUANTUM + 1);

    sched_state_t         state_q, state_d;
    logic [TAG_WIDTH-1:0] owner_q, owner_d;
    logic [TAG_WIDTH-1:0] last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [FLUX-1:0]      ready;
    logic [TAG_WIDTH-1:0] pick_start;
    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_idx;
    logic                 fire;
    logic                 fire_g;
    logic [TAG_WIDTH-1:0] grant;

    function automatic logic [TAG_WIDTH-1:0] next_idx(input logic [TAG_WIDTH-1:0] x);
        return (x == TAG_WIDTH'(FLUX - 1)) ? '0 : x + 1'b1;
    endfunction

    assign ready = ~empty_a & ~empty_b & {FLUX{~full}};

    rr_pick #(
        .N (FLUX),
        .W (TAG_WIDTH)
    ) u_pick (
        .ready (ready),
        .start (pick_start),
        .found (pick_found),
        .index (pick_idx)
    );

    // State, owner, release pointer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= TAG_WIDTH'(FLUX - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and grant decision from registered state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        fire       = 1'b0;
        grant      = '0;
        pick_start = next_idx(last_q);
        case (state_q)
            IDLE: begin
                pick_start = next_idx(last_q);
                if (pick_found) begin
                    fire  = 1'b1;
                    grant = pick_idx;
                    if (QUANTUM == 1) begin
                        last_d = pick_idx;
                    end else begin
                        state_d = BURST;
                        owner_d = pick_idx;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            BURST: begin
                pick_start = next_idx(owner_q);
                if (ready[owner_q]) begin
                    fire  = 1'b1;
                    grant = owner_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CNT_WIDTH'(QUANTUM)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end else if (full) begin
                    // Backpressure: hold the turn untouched.
                    state_d = BURST;
                end else begin
                    // Owner starved: release and hand over in the same cycle.
                    last_d = owner_q;
                    if (pick_found) begin
                        fire  = 1'b1;
                        grant = pick_idx;
                        if (QUANTUM == 1) begin
                            state_d = IDLE;
                            last_d  = pick_idx;
                        end else begin
                            owner_d = pick_idx;
                            cnt_d   = CNT_WIDTH'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fire_g = fire & rst_n;

    // One-hot strobes and tag, forced to zero while reset is asserted.
    always_comb begin
        read_a = '0;
        for (int i = 0; i < FLUX; i++) begin
            read_a[i] = fire_g && (grant == TAG_WIDTH'(i));
        end
    end

    assign read_b = read_a;
    assign write  = fire_g;
    assign tag    = fire_g ? grant : '0;
    assign owner  = rst_n ? owner_q : '0;
    assign busy   = rst_n && (state_q == BURST);

`ifdef FLUX_SCHED_STATS_EN
    for (genvar i = 0; i < FLUX; i++) begin : g_stat
        logic [STAT_WIDTH-1:0] count_q;

        // Saturating per-flux fire counter; clear beats increment.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else if (stat_clr) begin
                count_q <= '0;
            end else if (read_a[i] && (count_q != {STAT_WIDTH{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end

        assign stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] = count_q;
    end
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed bench for flux_rr_scheduler: a FLUX=4/QUANTUM=2 instance and a
// FLUX=3/QUANTUM=1 instance, expectations queued per cycle and checked at
// the falling edge. Stats checks compile in with FLUX_SCHED_STATS_EN.
module tb_flux_rr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: FLUX=4, QUANTUM=2
    logic       rst_a, full_a;
    logic [3:0] ea_a, eb_a;
    logic [3:0] rda_a, rdb_a;
    logic       wr_a, busy_a;
    logic [1:0] tag_a, own_a;

    // Instance B: FLUX=3, QUANTUM=1
    logic       rst_b, full_b;
    logic [2:0] ea_b, eb_b;
    logic [2:0] rda_b, rdb_b;
    logic       wr_b, busy_b;
    logic [1:0] tag_b, own_b;

`ifdef FLUX_SCHED_STATS_EN
    logic        clr_a = 1'b0, clr_b = 1'b0;
    logic [63:0] stat_a;
    logic [47:0] stat_b;
`endif

    flux_rr_scheduler #(.FLUX(4), .QUANTUM(2)) u_a (
        .clk     (clk),
        .rst_n   (rst_a),
        .empty_a (ea_a),
        .empty_b (eb_a),
        .full    (full_a),
        .read_a  (rda_a),
        .read_b  (rdb_a),
        .write   (wr_a),
        .tag     (tag_a),
        .owner   (own_a),
        .busy    (busy_a)
`ifdef FLUX_SCHED_STATS_EN
        ,
        .stat_clr (clr_a),
        .stat_cnt (stat_a)
`endif
    );

    flux_rr_scheduler #(.FLUX(3), .QUANTUM(1)) u_b (
        .clk     (clk),
        .rst_n   (rst_b),
        .empty_a (ea_b),
        .empty_b (eb_b),
        .full    (full_b),
        .read_a  (rda_b),
        .read_b  (rdb_b),
        .write   (wr_b),
        .tag     (tag_b),
        .owner   (own_b),
        .busy    (busy_b)
`ifdef FLUX_SCHED_STATS_EN
        ,
        .stat_clr (clr_b),
        .stat_cnt (stat_b)
`endif
    );

    typedef struct {
        int         dut;
        logic       w;
        logic [3:0] rd;
        logic [1:0] tg;
        logic [1:0] ow;
        logic       bz;
        string      nm;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // One cycle: drive after the rising edge, queue expectation, check at falling edge.
    task automatic step(input int dut, input logic [3:0] ea, input logic [3:0] eb,
                        input logic f, input logic r,
                        input logic w, input logic [3:0] rd, input logic [1:0] tg,
                        input logic [1:0] ow, input logic bz, input string nm);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        if (dut == 0) begin
            ea_a = ea; eb_a = eb; full_a = f; rst_a = r;
        end else begin
            ea_b = ea[2:0]; eb_b = eb[2:0]; full_b = f; rst_b = r;
        end
        e.dut = dut; e.w = w; e.rd = rd; e.tg = tg; e.ow = ow; e.bz = bz; e.nm = nm;
        sbq.push_back(e);
        @(negedge clk);
        g = sbq.pop_front();
        if (g.dut == 0) begin
            chk({g.nm, ".write"},  32'(wr_a),   32'(g.w));
            chk({g.nm, ".read_a"}, 32'(rda_a),  32'(g.rd));
            chk({g.nm, ".read_b"}, 32'(rdb_a),  32'(g.rd));
            chk({g.nm, ".tag"},    32'(tag_a),  32'(g.tg));
            chk({g.nm, ".owner"},  32'(own_a),  32'(g.ow));
            chk({g.nm, ".busy"},   32'(busy_a), 32'(g.bz));
        end else begin
            chk({g.nm, ".write"},  32'(wr_b),   32'(g.w));
            chk({g.nm, ".read_a"}, 32'(rda_b),  32'(g.rd));
            chk({g.nm, ".read_b"}, 32'(rdb_b),  32'(g.rd));
            chk({g.nm, ".tag"},    32'(tag_b),  32'(g.tg));
            chk({g.nm, ".owner"},  32'(own_b),  32'(g.ow));
            chk({g.nm, ".busy"},   32'(busy_b), 32'(g.bz));
        end
    endtask

    initial begin
        rst_a = 1'b0; full_a = 1'b0; ea_a = 4'hF; eb_a = 4'hF;
        rst_b = 1'b0; full_b = 1'b0; ea_b = 3'h7; eb_b = 3'h7;

        // Reset state on A
        step(0, 4'hF, 4'hF, 0, 0,  0, 4'b0000, 0, 0, 0, "a_reset");
        step(0, 4'hF, 4'hF, 0, 0,  0, 4'b0000, 0, 0, 0, "a_reset");

        // All FIFOs empty for 10 cycles
        for (int i = 0; i < 10; i++)
            step(0, 4'hF, 4'hF, 0, 1,  0, 4'b0000, 0, 0, 0, "a_empty");

        // Fluxes 0 and 2 ready: 0,0,2,2,0,0,2,2
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0001, 0, 0, 0, "a_rr1");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0001, 0, 0, 1, "a_rr2");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0100, 2, 0, 0, "a_rr3");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0100, 2, 2, 1, "a_rr4");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0001, 0, 2, 0, "a_rr5");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0001, 0, 0, 1, "a_rr6");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0100, 2, 0, 0, "a_rr7");
        step(0, 4'b1010, 4'b1010, 0, 1,  1, 4'b0100, 2, 2, 1, "a_rr8");

        // Owner 1 after one transfer, then full for 3 cycles
        step(0, 4'b1101, 4'b1101, 0, 1,  1, 4'b0010, 1, 2, 0, "a_own1");
        for (int i = 0; i < 3; i++)
            step(0, 4'b0101, 4'b0101, 1, 1,  0, 4'b0000, 0, 1, 1, "a_full_hold");
        step(0, 4'b0101, 4'b0101, 0, 1,  1, 4'b0010, 1, 1, 1, "a_full_drop");
        step(0, 4'b0101, 4'b0101, 0, 1,  1, 4'b1000, 3, 1, 0, "a_rot3a");
        step(0, 4'b0101, 4'b0101, 0, 1,  1, 4'b1000, 3, 3, 1, "a_rot3b");

        // Owner 0 starves mid-burst, flux 3 takes over in the same cycle
        step(0, 4'b0110, 4'b0110, 0, 1,  1, 4'b0001, 0, 3, 0, "a_own0");
        step(0, 4'b0111, 4'b0110, 0, 1,  1, 4'b1000, 3, 0, 1, "a_starve");
        step(0, 4'b0111, 4'b0110, 0, 1,  1, 4'b1000, 3, 3, 1, "a_after_sw");
        step(0, 4'hF,    4'hF,    0, 1,  0, 4'b0000, 0, 3, 0, "a_drain");

        // Reset mid-burst with owner 2
        step(0, 4'b1011, 4'b1011, 0, 1,  1, 4'b0100, 2, 3, 0, "a_own2");
`ifdef FLUX_SCHED_STATS_EN
        chk("a_stat2_pre", 32'(stat_a[47:32]), 32'd4);
`endif
        step(0, 4'b1011, 4'b1011, 0, 0,  0, 4'b0000, 0, 0, 0, "a_rst_mid");
`ifdef FLUX_SCHED_STATS_EN
        chk("a_stat_rst", 32'(stat_a == 64'd0), 32'd1);
`endif
        step(0, 4'b1011, 4'b1011, 0, 0,  0, 4'b0000, 0, 0, 0, "a_rst_mid");
        step(0, 4'b0000, 4'b0000, 0, 1,  1, 4'b0001, 0, 0, 0, "a_post_rst1");
        step(0, 4'b0000, 4'b0000, 0, 1,  1, 4'b0001, 0, 0, 1, "a_post_rst2");
        step(0, 4'b0000, 4'b0000, 0, 1,  1, 4'b0010, 1, 0, 0, "a_post_rst3");

        // Instance B: QUANTUM=1, FLUX=3 wrap
        step(1, 4'h7, 4'h7, 0, 0,  0, 4'b0000, 0, 0, 0, "b_reset");
        step(1, 4'h0, 4'h0, 0, 1,  1, 4'b0001, 0, 0, 0, "b_wrap0");
        step(1, 4'h0, 4'h0, 0, 1,  1, 4'b0010, 1, 0, 0, "b_wrap1");
        step(1, 4'h0, 4'h0, 0, 1,  1, 4'b0100, 2, 0, 0, "b_wrap2");
        step(1, 4'h0, 4'h0, 0, 1,  1, 4'b0001, 0, 0, 0, "b_wrap3");
        step(1, 4'h0, 4'h0, 0, 1,  1, 4'b0010, 1, 0, 0, "b_wrap4");
        step(1, 4'h5, 4'h0, 0, 1,  1, 4'b0010, 1, 0, 0, "b_single1");
        step(1, 4'h5, 4'h0, 0, 1,  1, 4'b0010, 1, 0, 0, "b_single2");
        step(1, 4'h0, 4'h0, 1, 1,  0, 4'b0000, 0, 0, 0, "b_full");
        step(1, 4'h0, 4'h0, 0, 1,  1, 4'b0100, 2, 0, 0, "b_after_full");

`ifdef FLUX_SCHED_STATS_EN
        // Long single-flux run on B to saturate counter 0, then clear while firing
        @(posedge clk); #1;
        ea_b = 3'b110; eb_b = 3'b110; full_b = 1'b0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("b_stat0_sat", 32'(stat_b[15:0]), 32'h0000FFFF);
        @(posedge clk); #1;
        clr_b = 1'b1;
        @(posedge clk); #1;
        chk("b_stat0_clr", 32'(stat_b[15:0]), 32'd0);
        clr_b = 1'b0;
        @(posedge clk); #1;
        chk("b_stat0_inc", 32'(stat_b[15:0]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
